rtc_txn_scheduler: RTL and testbench

Sequences the RTC bus signal generator (the block that drives the multiplexed A/D, CS, WR and RD lines).
- After reset, issues a fixed initialisation write pair.
- Then periodically sweeps the time registers into a coherent shadow bank.
- Arbitrates host write requests (time setting) against the refresh sweep.
- Sits between the host/register interface and the signal generator; only this block ever starts a generator transaction.

---
 rtl/rtc_sched_pkg.sv | 24 ++
 rtl/rtc_txn_scheduler_if.sv | 21 ++
 rtl/rtc_refresh_timer.sv | 49 ++++
 rtl/rtc_txn_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_rtc_txn_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_sched_pkg.sv
// Shared types and defaults for the RTC transaction scheduler.
package rtc_sched_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR  = 8'h21;
    localparam logic [ADDR_W-1:0] DEF_INIT_ADDR0 = 8'h02;
    localparam logic [DATA_W-1:0] DEF_INIT_DATA0 = 8'h10;
    localparam logic [ADDR_W-1:0] DEF_INIT_ADDR1 = 8'h00;
    localparam logic [DATA_W-1:0] DEF_INIT_DATA1 = 8'h00;

    typedef enum logic [2:0] {
        S_INIT0    = 3'd0,
        S_INIT1    = 3'd1,
        S_IDLE     = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_RD_ISSUE = 3'd5,
        S_RD_WAIT  = 3'd6,
        S_COMMIT   = 3'd7
    } sched_state_e;

endpackage

// File: rtl/rtc_txn_scheduler_if.sv
// Scheduler <-> bus signal generator transaction handshake.
interface rtc_txn_scheduler_if;

    logic                              sig_start;
    logic                              sig_wr;
    logic [rtc_sched_pkg::ADDR_W-1:0]  sig_addr;
    logic [rtc_sched_pkg::DATA_W-1:0]  sig_wdata;
    logic                              sig_done;
    logic [rtc_sched_pkg::DATA_W-1:0]  sig_rdata;

    modport master (
        output sig_start, sig_wr, sig_addr, sig_wdata,
        input  sig_done, sig_rdata
    );

    modport slave (
        input  sig_start, sig_wr, sig_addr, sig_wdata,
        output sig_done, sig_rdata
    );

endinterface

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh period counter with a saturating request flag.
module rtc_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic pending
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             wrap;

    // Count while running; a wrap that lands on a clear still leaves a request.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        wrap      = 1'b0;
        if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (clear) pending_d = 1'b0;
        if (wrap)  pending_d = 1'b1;
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/rtc_txn_scheduler.sv
// Sequences init writes, periodic time sweeps and host writes onto the
// RTC bus signal generator.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_INIT0    | first init write: issue once, then wait for sig_done
// S_INIT1    | second init write: issue once, then wait for sig_done
// S_IDLE     | pick pending host write, else pending refresh sweep
// S_WR_ISSUE | one-cycle start of a host write
// S_WR_WAIT  | wait for host write completion or timeout
// S_RD_ISSUE | one-cycle start of sweep read idx
// S_RD_WAIT  | wait for read data; chain to next read or commit
// S_COMMIT   | copy staging bank to time_regs in one cycle
module rtc_txn_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int unsigned       NUM_REGS       = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned       REFRESH_CYCLES = 1000000,
    parameter int unsigned       TIMEOUT        = 4095,
    parameter logic [ADDR_W-1:0] INIT_ADDR0     = DEF_INIT_ADDR0,
    parameter logic [DATA_W-1:0] INIT_DATA0     = DEF_INIT_DATA0,
    parameter logic [ADDR_W-1:0] INIT_ADDR1     = DEF_INIT_ADDR1,
    parameter logic [DATA_W-1:0] INIT_DATA1     = DEF_INIT_DATA1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       usr_wr_req,
    input  logic [ADDR_W-1:0]          usr_addr,
    input  logic [DATA_W-1:0]          usr_data,
    output logic                       usr_busy,
    output logic                       usr_wr_ack,
    rtc_txn_scheduler_if.master        bus,
    output logic [DATA_W*NUM_REGS-1:0] time_regs,
    output logic                       time_valid,
    output logic                       time_update,
    output logic                       err_timeout
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT);

    sched_state_e state_q, state_d;
    logic                              issued_q, issued_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [TO_W-1:0]                   wait_q, wait_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   staging_q, staging_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   time_regs_q, time_regs_d;
    logic                              busy_q, busy_d;
    logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]                 wr_data_q, wr_data_d;
    logic                              ack_q, ack_d;
    logic                              start_q, start_d;
    logic                              wr_q, wr_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic [DATA_W-1:0]                 wdata_q, wdata_d;
    logic                              valid_q, valid_d;
    logic                              update_q, update_d;
    logic                              err_q, err_d;
    logic                              run_q, run_d;

    logic refresh_pending;
    logic refresh_clear;
    logic waiting;
    logic done_ok;
    logic timed_out;

    rtc_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (run_q),
        .clear   (refresh_clear),
        .pending (refresh_pending)
    );

    // Next-state, transaction launch and bookkeeping. Bus outputs are
    // registered so they are clean during and right after reset.
    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        idx_d         = idx_q;
        staging_d     = staging_q;
        time_regs_d   = time_regs_q;
        busy_d        = busy_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        ack_d         = 1'b0;
        start_d       = 1'b0;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        valid_d       = valid_q;
        update_d      = 1'b0;
        err_d         = err_q;
        run_d         = run_q;
        refresh_clear = 1'b0;
        wait_d        = (wait_q != '0) ? wait_q - 1'b1 : wait_q;

        if (usr_wr_req && !busy_q) begin
            busy_d    = 1'b1;
            wr_addr_d = usr_addr;
            wr_data_d = usr_data;
        end

        // The start cycle of an init write counts as its issue cycle.
        waiting = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT) ||
                  (((state_q == S_INIT0) || (state_q == S_INIT1)) && issued_q && !start_q);
        done_ok   = waiting && bus.sig_done;
        timed_out = waiting && !bus.sig_done && (wait_q == '0);
        if (timed_out) err_d = 1'b1;

        case (state_q)
            S_INIT0: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                    start_d  = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = INIT_ADDR0;
                    wdata_d  = INIT_DATA0;
                end else if (done_ok) begin
                    issued_d = 1'b0;
                    state_d  = S_INIT1;
                end else if (timed_out) begin
                    issued_d = 1'b0;
                    run_d    = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_INIT1: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                    start_d  = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = INIT_ADDR1;
                    wdata_d  = INIT_DATA1;
                end else if (done_ok || timed_out) begin
                    issued_d = 1'b0;
                    run_d    = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_IDLE: begin
                if (busy_q) begin
                    state_d = S_WR_ISSUE;
                    start_d = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = wr_addr_q;
                    wdata_d = wr_data_q;
                end else if (refresh_pending) begin
                    state_d       = S_RD_ISSUE;
                    refresh_clear = 1'b1;
                    idx_d         = '0;
                    start_d       = 1'b1;
                    wr_d          = 1'b0;
                    addr_d        = BASE_ADDR;
                    wdata_d       = '0;
                end
            end
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (done_ok) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (done_ok) begin
                    staging_d[idx_q] = bus.sig_rdata;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_ISSUE;
                        start_d = 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end
                end else if (timed_out) begin
                    staging_d = '0;
                    state_d   = S_IDLE;
                end
            end
            S_COMMIT: begin
                time_regs_d = staging_q;
                update_d    = 1'b1;
                valid_d     = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT0;
        endcase

        if (start_d) wait_d = TO_LOAD;
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT0;
            issued_q    <= 1'b0;
            idx_q       <= '0;
            wait_q      <= '0;
            staging_q   <= '0;
            time_regs_q <= '0;
            busy_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ack_q       <= 1'b0;
            start_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            staging_q   <= staging_d;
            time_regs_q <= time_regs_d;
            busy_q      <= busy_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
            run_q       <= run_d;
        end
    end

    assign bus.sig_start = start_q;
    assign bus.sig_wr    = wr_q;
    assign bus.sig_addr  = addr_q;
    assign bus.sig_wdata = wdata_q;
    assign usr_busy      = busy_q;
    assign usr_wr_ack    = ack_q;
    assign time_regs     = time_regs_q;
    assign time_valid    = valid_q;
    assign time_update   = update_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_rtc_txn_scheduler.sv
// Bench for rtc_txn_scheduler: generator BFM, transaction log and a
// transaction-level model of the expected bus traffic.
module tb_rtc_txn_scheduler;

    localparam int R = 200;
    localparam int T = 50;
    localparam int N = 6;
    localparam logic [7:0] BASE = 8'h21;

    typedef struct {
        int       cyc;
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic usr_wr_req;
    logic [7:0] usr_addr, usr_data;
    logic usr_busy, usr_wr_ack;
    logic [8*N-1:0] time_regs;
    logic time_valid, time_update, err_timeout;

    rtc_txn_scheduler_if bus();

    rtc_txn_scheduler #(
        .NUM_REGS       (N),
        .REFRESH_CYCLES (R),
        .TIMEOUT        (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .usr_wr_req  (usr_wr_req),
        .usr_addr    (usr_addr),
        .usr_data    (usr_data),
        .usr_busy    (usr_busy),
        .usr_wr_ack  (usr_wr_ack),
        .bus         (bus),
        .time_regs   (time_regs),
        .time_valid  (time_valid),
        .time_update (time_update),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    txn_t txn_q[$];
    txn_t exp_q[$];
    int ack_cnt = 0;
    int upd_cnt = 0;
    int err_cyc = -1;

    // Observe the DUT mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sig_start) begin
                txn_t t;
                t.cyc   = cyc;
                t.wr    = bus.sig_wr;
                t.addr  = bus.sig_addr;
                t.wdata = bus.sig_wdata;
                txn_q.push_back(t);
            end
            if (usr_wr_ack)  ack_cnt++;
            if (time_update) upd_cnt++;
            if (err_timeout && err_cyc < 0) err_cyc = cyc;
        end
    end

    // Generator BFM: sig_done 10 cycles after sig_start, rdata = 30h + addr[3:0].
    int       bfm_cnt = 0;
    bit       bfm_wr;
    bit [7:0] bfm_addr, bfm_wdata;
    bit       hold_en = 0;
    bit [7:0] hold_addr = 8'h23;

    always @(negedge clk) begin
        bus.sig_done = 1'b0;
        if (reset) begin
            bfm_cnt = 0;
        end else begin
            if (bfm_cnt > 0) begin
                bfm_cnt--;
                if (bfm_cnt == 0) begin
                    chk("bus_hold", {bus.sig_wr, bus.sig_addr, bfm_wr ? bus.sig_wdata : 8'h00},
                        {bfm_wr, bfm_addr, bfm_wr ? bfm_wdata : 8'h00});
                    bus.sig_done  = 1'b1;
                    bus.sig_rdata = 8'h30 + {4'h0, bfm_addr[3:0]};
                end
            end
            if (bus.sig_start) begin
                bfm_wr    = bus.sig_wr;
                bfm_addr  = bus.sig_addr;
                bfm_wdata = bus.sig_wdata;
                if (hold_en && !bus.sig_wr && bus.sig_addr == hold_addr) begin
                    hold_en = 0;
                    bfm_cnt = 0;
                end else begin
                    bfm_cnt = 10;
                end
            end
        end
    end

    // Transaction-level model.
    function automatic txn_t mk(input bit wr, input bit [7:0] a, input bit [7:0] d);
        txn_t t;
        t.cyc = 0; t.wr = wr; t.addr = a; t.wdata = wr ? d : 8'h00;
        return t;
    endfunction

    task automatic model_init();
        exp_q.push_back(mk(1, 8'h02, 8'h10));
        exp_q.push_back(mk(1, 8'h00, 8'h00));
    endtask

    task automatic model_reads(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, BASE + 8'(i), 8'h00));
    endtask

    function automatic logic [8*N-1:0] model_regs();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) begin
            logic [7:0] a;
            a = BASE + 8'(i);
            v[8*i +: 8] = 8'h30 + {4'h0, a[3:0]};
        end
        return v;
    endfunction

    task automatic cmp_log(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (i < txn_q.size() && i < exp_q.size()) begin
                chk($sformatf("txn%0d", i),
                    {txn_q[i].wr, txn_q[i].addr, txn_q[i].wr ? txn_q[i].wdata : 8'h00},
                    {exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata});
            end else begin
                chk($sformatf("txn%0d_missing", i), 0, 1);
            end
        end
    endtask

    task automatic wait_txns(input int n, input int budget, input string tag);
        int k = 0;
        while (txn_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, txn_q.size() >= n, 1);
    endtask

    task automatic wait_upd(input int n, input int budget, input string tag);
        int k = 0;
        while (upd_cnt < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, upd_cnt >= n, 1);
    endtask

    task automatic host_write(input bit [7:0] a, input bit [7:0] d);
        usr_wr_req = 1'b1; usr_addr = a; usr_data = d;
        @(negedge clk);
        usr_wr_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, bus.sig_start, 0);
        chk({tag, "_busy"},  usr_busy, 0);
        chk({tag, "_ack"},   usr_wr_ack, 0);
        chk({tag, "_regs"},  time_regs, 0);
        chk({tag, "_valid"}, time_valid, 0);
        chk({tag, "_upd"},   time_update, 0);
        chk({tag, "_err"},   err_timeout, 0);
        chk({tag, "_bus"},   {bus.sig_wr, bus.sig_addr, bus.sig_wdata}, 0);
    endtask

    int f1, w1, w, k, base_n, upd0;
    logic [8*N-1:0] regs0;
    bit [7:0] ra, rd;

    initial begin
        reset = 1'b1; usr_wr_req = 1'b0; usr_addr = '0; usr_data = '0;
        bus.sig_done = 1'b0; bus.sig_rdata = '0;
        repeat (4) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Init writes, then nothing until the first refresh sweep.
        model_init();
        model_reads(N);
        wait_txns(3, R + 100, "first_read_to");
        f1 = (txn_q.size() >= 3) ? txn_q[2].cyc : 0;
        chk("refresh_lat", ((f1 - (txn_q[1].cyc + 10)) >= R) && ((f1 - (txn_q[1].cyc + 10)) <= R + 3), 1);
        wait_txns(8, 100, "sweep1_to");
        cmp_log(0, 7);
        for (int i = 3; i < 8 && i < txn_q.size(); i++)
            chk("rd_back2back", txn_q[i].cyc - txn_q[i-1].cyc, 11);
        wait_upd(1, 40, "commit1_to");
        @(negedge clk);
        chk("regs1", time_regs, model_regs());
        chk("valid1", time_valid, 1);
        chk("upd1", upd_cnt, 1);
        w1 = f1 - 2;

        // Host write arriving mid-sweep waits for the commit.
        model_reads(N);
        exp_q.push_back(mk(1, 8'h22, 8'h59));
        wait_txns(11, R + 50, "sweep2_to");
        repeat ($urandom_range(1, 5)) @(negedge clk);
        host_write(8'h22, 8'h59);
        chk("busy_set", usr_busy, 1);
        repeat (2) @(negedge clk);
        host_write(8'($urandom), 8'($urandom));
        k = 0;
        while (ack_cnt < 1 && k < 200) begin @(negedge clk); k++; end
        chk("ack1_to", ack_cnt, 1);
        chk("busy_clr", usr_busy, 0);
        cmp_log(8, 14);
        if (txn_q.size() >= 15) chk("wr_after_commit", txn_q[14].cyc - txn_q[13].cyc, 13);
        repeat (30) @(negedge clk);
        chk("ack_once", ack_cnt, 1);
        chk("busy_ignored", txn_q.size(), 15);
        chk("upd2", upd_cnt, 2);

        // Refresh wrap and host request in the same cycle: write goes first.
        w = w1;
        while (w <= cyc + 3) w += R;
        k = 0;
        while (cyc < w && k < 2 * R) begin @(negedge clk); k++; end
        chk("wrap_align", cyc, w);
        ra = 8'($urandom); rd = 8'($urandom);
        exp_q.push_back(mk(1, ra, rd));
        model_reads(N);
        host_write(ra, rd);
        wait_txns(22, 150, "sweep3_to");
        cmp_log(15, 21);
        if (txn_q.size() >= 16) chk("wrap_wr_lat", txn_q[15].cyc - w, 2);
        wait_upd(3, 100, "commit3_to");
        chk("ack2", ack_cnt, 2);

        // Read 0x23 never answered: sticky timeout, bank untouched.
        @(negedge clk);
        regs0 = time_regs;
        upd0  = upd_cnt;
        hold_en = 1;
        exp_q.push_back(mk(0, 8'h21, 0));
        exp_q.push_back(mk(0, 8'h22, 0));
        exp_q.push_back(mk(0, 8'h23, 0));
        k = 0;
        while (err_cyc < 0 && k < 2 * R + 100) begin @(negedge clk); k++; end
        chk("err_to", err_cyc >= 0, 1);
        if (txn_q.size() >= 25)
            chk("err_delay", ((err_cyc - txn_q[24].cyc) >= T) && ((err_cyc - txn_q[24].cyc) <= T + 3), 1);
        repeat (5) @(negedge clk);
        chk("err_set", err_timeout, 1);
        chk("regs_kept", time_regs, regs0);
        chk("no_upd_on_err", upd_cnt, upd0);
        chk("valid_kept", time_valid, 1);
        chk("sweep_aborted", txn_q.size(), 25);
        cmp_log(22, 24);

        ra = 8'($urandom); rd = 8'($urandom);
        exp_q.push_back(mk(1, ra, rd));
        host_write(ra, rd);
        model_reads(N);
        wait_upd(upd0 + 1, 2 * R, "sweep5_to");
        @(negedge clk);
        cmp_log(25, 31);
        chk("regs5", time_regs, model_regs());
        chk("err_sticky", err_timeout, 1);
        chk("ack3", ack_cnt, 3);

        // Reset in the middle of a sweep read.
        base_n = txn_q.size();
        wait_txns(base_n + 1, R + 50, "sweep6_to");
        if (txn_q.size() > base_n) chk("sweep6_first", txn_q[base_n].addr, BASE);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base_n = txn_q.size();
        wait_txns(base_n + 2, 60, "reinit_to");
        if (txn_q.size() >= base_n + 2) begin
            chk("reinit0", {txn_q[base_n].wr, txn_q[base_n].addr, txn_q[base_n].wdata}, {1'b1, 8'h02, 8'h10});
            chk("reinit1", {txn_q[base_n+1].wr, txn_q[base_n+1].addr, txn_q[base_n+1].wdata}, {1'b1, 8'h00, 8'h00});
        end
        chk("reinit_valid", time_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
